// File: rtl/uart_transmitter.sv
// UART serial transmit engine: start bit, DATA_BITS data bits LSB first, stop bit.
// Define UART_TRANSMITTER_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_transmitter #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 8,
  parameter int MIN_DIV   = 5
) (
  input  logic                 clk,
  input  logic                 notreset,
  input  logic                 notenable,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV_W = DIV_WIDTH'(MIN_DIV);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TRANSMITTER_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
`ifdef UART_TRANSMITTER_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic                 accept;
  logic                 bit_done;
  logic [DIV_WIDTH-1:0] eff_div;

  // Ready is forced low while reset is asserted so nothing can be handshaked then.
  assign tx_ready = (state_q == IDLE) & ~notenable & notreset;
  assign busy     = (state_q != IDLE);
  assign accept   = tx_valid & tx_ready;
  assign eff_div  = (divisor < MIN_DIV_W) ? MIN_DIV_W : divisor;
  assign bit_done = (cnt_q == div_q - DIV_WIDTH'(1));

  always_ff @(posedge clk or negedge notreset) begin
    if (!notreset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= MIN_DIV_W;
      idx_q    <= '0;
      shift_q  <= '0;
`ifdef UART_TRANSMITTER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
`ifdef UART_TRANSMITTER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // txd is decoded from the state register, so an async reset returns the line high at once.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
`ifdef UART_TRANSMITTER_PARITY_EN
    parity_d = parity_q;
`endif
    txd      = 1'b1;

    if (state_q != IDLE) begin
      cnt_d = bit_done ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    unique case (state_q)
      IDLE: begin
        txd = 1'b1;
        if (accept) begin
          state_d  = START;
          cnt_d    = '0;
          div_d    = eff_div;
          shift_d  = tx_data;
`ifdef UART_TRANSMITTER_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      START: begin
        txd = 1'b0;
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        txd = shift_q[0];
        if (bit_done) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
`ifdef UART_TRANSMITTER_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TRANSMITTER_PARITY_EN
      PARITY: begin
        txd = parity_q;
        if (bit_done) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        txd = 1'b1;
        if (bit_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        txd     = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomized self-checking bench for uart_transmitter against a bit-timing model of the serial frame.
module tb_uart_transmitter;

`ifdef UART_TRANSMITTER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk;
  logic       notreset;
  logic       notenable;
  logic [7:0] divisor;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       busy;

  int nChecks = 0;
  int nFail   = 0;

  uart_transmitter #(.DATA_BITS(8), .DIV_WIDTH(8), .MIN_DIV(5)) dut (
    .clk       (clk),
    .notreset  (notreset),
    .notenable (notenable),
    .divisor   (divisor),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .txd       (txd),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int effDiv(input int div);
    return (div < 5) ? 5 : div;
  endfunction

  function automatic int frameLen(input int div);
    return (10 + int'(PAR)) * effDiv(div);
  endfunction

  // Expected line level k cycles after the accepting edge.
  function automatic logic expTxd(input logic [7:0] d, input int div, input int k);
    int b;
    b = k / effDiv(div);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PAR && b == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic test_reset();
    notreset  = 1'b0;
    notenable = 1'b0;
    tx_valid  = 1'b1;
    tx_data   = 8'h81;
    divisor   = 8'd5;
    repeat (2) @(negedge clk);
    nChecks++;
    if (txd !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_state: txd=%b busy=%b tx_ready=%b, required 1 0 0", txd, busy, tx_ready);
    end
    tx_valid = 1'b0;
    notreset = 1'b1;
    #1;
    nChecks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_release: tx_ready=%b busy=%b, required 1 0", tx_ready, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_pattern();
    logic [7:0] bytes [2];
    bytes[0] = 8'hA5;
    bytes[1] = 8'h07;
    for (int f = 0; f < 2; f++) begin
      divisor  = 8'd5;
      tx_data  = bytes[f];
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      for (int k = 0; k < frameLen(5); k++) begin
        @(negedge clk);
        nChecks++;
        if (txd !== expTxd(bytes[f], 5, k) || busy !== 1'b1) begin
          nFail++;
          $display("[TB] FAIL pattern_%02h k=%0d: txd=%b busy=%b, required txd=%b busy=1",
                   bytes[f], k, txd, busy, expTxd(bytes[f], 5, k));
        end
      end
      @(negedge clk);
      nChecks++;
      if (tx_ready !== 1'b1 || txd !== 1'b1 || busy !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL pattern_end_%02h: tx_ready=%b txd=%b busy=%b, required 1 1 0",
                 bytes[f], tx_ready, txd, busy);
      end
    end
  endtask

  task automatic test_clamp();
    logic [7:0] bytes [3];
    int         divs  [3];
    bytes[0] = 8'h00; divs[0] = 3;
    bytes[1] = 8'h00; divs[1] = 0;
    bytes[2] = 8'hFF; divs[2] = 16;
    for (int f = 0; f < 3; f++) begin
      divisor  = 8'(divs[f]);
      tx_data  = bytes[f];
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      for (int k = 0; k < frameLen(divs[f]); k++) begin
        @(negedge clk);
        nChecks++;
        if (txd !== expTxd(bytes[f], divs[f], k) || busy !== 1'b1) begin
          nFail++;
          $display("[TB] FAIL clamp_div%0d k=%0d: txd=%b busy=%b, required txd=%b busy=1",
                   divs[f], k, txd, busy, expTxd(bytes[f], divs[f], k));
        end
      end
      @(negedge clk);
      nChecks++;
      if (busy !== 1'b0 || tx_ready !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL clamp_len_div%0d: busy=%b tx_ready=%b, required 0 1", divs[f], busy, tx_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int         div;
    for (int f = 0; f < 8; f++) begin
      d        = 8'($urandom);
      div      = $urandom_range(0, 12);
      divisor  = 8'(div);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 begin
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        divisor  = 8'($urandom);
      end
      for (int k = 0; k < frameLen(div); k++) begin
        @(negedge clk);
        nChecks++;
        if (txd !== expTxd(d, div, k) || busy !== 1'b1) begin
          nFail++;
          $display("[TB] FAIL random_%02h_div%0d k=%0d: txd=%b busy=%b, required txd=%b busy=1",
                   d, div, k, txd, busy, expTxd(d, div, k));
        end
      end
      @(negedge clk);
      nChecks++;
      if (busy !== 1'b0 || txd !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL random_end_%02h: busy=%b txd=%b, required 0 1", d, busy, txd);
      end
    end
  endtask

  task automatic test_back_to_back();
    divisor  = 8'd5;
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_data = 8'h0F;
    for (int k = 0; k < frameLen(5); k++) begin
      @(negedge clk);
      nChecks++;
      if (txd !== expTxd(8'h55, 5, k)) begin
        nFail++;
        $display("[TB] FAIL b2b_first k=%0d: txd=%b, required %b", k, txd, expTxd(8'h55, 5, k));
      end
    end
    @(negedge clk);
    nChecks++;
    if (txd !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL b2b_gap: txd=%b busy=%b tx_ready=%b, required 1 0 1", txd, busy, tx_ready);
    end
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int k = 0; k < frameLen(5); k++) begin
      @(negedge clk);
      nChecks++;
      if (txd !== expTxd(8'h0F, 5, k) || busy !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL b2b_second k=%0d: txd=%b busy=%b, required txd=%b busy=1",
                 k, txd, busy, expTxd(8'h0F, 5, k));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_divisor_change();
    divisor  = 8'd5;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int k = 0; k < frameLen(5); k++) begin
      @(negedge clk);
      nChecks++;
      if (txd !== expTxd(8'h3C, 5, k)) begin
        nFail++;
        $display("[TB] FAIL divchg_old k=%0d: txd=%b, required %b", k, txd, expTxd(8'h3C, 5, k));
      end
      if (k == 10) divisor = 8'd20;
    end
    @(negedge clk);
    tx_data  = 8'hE1;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int k = 0; k < frameLen(20); k++) begin
      @(negedge clk);
      nChecks++;
      if (txd !== expTxd(8'hE1, 20, k) || busy !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL divchg_new k=%0d: txd=%b busy=%b, required txd=%b busy=1",
                 k, txd, busy, expTxd(8'hE1, 20, k));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_notenable();
    divisor  = 8'd5;
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int k = 0; k < frameLen(5); k++) begin
      @(negedge clk);
      nChecks++;
      if (txd !== expTxd(8'h96, 5, k) || busy !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL disable_frame k=%0d: txd=%b busy=%b, required txd=%b busy=1",
                 k, txd, busy, expTxd(8'h96, 5, k));
      end
      if (k == 12) begin
        notenable = 1'b1;
        tx_valid  = 1'b1;
        tx_data   = 8'hFF;
      end
    end
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      nChecks++;
      if (tx_ready !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL disable_hold j=%0d: tx_ready=%b txd=%b busy=%b, required 0 1 0",
                 j, tx_ready, txd, busy);
      end
    end
    notenable = 1'b0;
    #1;
    nChecks++;
    if (tx_ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL disable_release: tx_ready=%b, required 1", tx_ready);
    end
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int k = 0; k < frameLen(5); k++) begin
      @(negedge clk);
      nChecks++;
      if (txd !== expTxd(8'hFF, 5, k)) begin
        nFail++;
        $display("[TB] FAIL disable_after k=%0d: txd=%b, required %b", k, txd, expTxd(8'hFF, 5, k));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    divisor  = 8'd5;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int k = 0; k <= 23; k++) begin
      @(negedge clk);
      nChecks++;
      if (txd !== expTxd(8'hC3, 5, k)) begin
        nFail++;
        $display("[TB] FAIL areset_pre k=%0d: txd=%b, required %b", k, txd, expTxd(8'hC3, 5, k));
      end
    end
    #2 notreset = 1'b0;
    #1;
    nChecks++;
    if (txd !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL areset_now: txd=%b busy=%b tx_ready=%b, required 1 0 0", txd, busy, tx_ready);
    end
    repeat (2) @(negedge clk);
    notreset = 1'b1;
    divisor  = 8'd7;
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int k = 0; k < frameLen(7); k++) begin
      @(negedge clk);
      nChecks++;
      if (txd !== expTxd(8'h5A, 7, k) || busy !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL areset_after k=%0d: txd=%b busy=%b, required txd=%b busy=1",
                 k, txd, busy, expTxd(8'h5A, 7, k));
      end
    end
    @(negedge clk);
    nChecks++;
    if (busy !== 1'b0 || tx_ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL areset_end: busy=%b tx_ready=%b, required 0 1", busy, tx_ready);
    end
  endtask

  initial begin
    notreset  = 1'b0;
    notenable = 1'b0;
    divisor   = 8'd5;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    test_reset();
    test_pattern();
    test_clamp();
    test_random();
    test_back_to_back();
    test_divisor_change();
    test_notenable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before the test sequence ended");
    $fatal(1, "[TB] time limit");
  end

endmodule
